// File: rtl/tdt_dtm_idr_q.sv
// DTM instruction/data register block with a pipelined DMI request queue.
// Bridges JTAG TAP capture/update strobes to an APB master valid/ready request port.
module tdt_dtm_idr_q #(
  parameter int unsigned DTM_IRREG_WIDTH = 5,
  parameter int unsigned DTM_ABITS       = 16,
  parameter int unsigned REQ_DEPTH       = 4,
  parameter logic [2:0]  IDLE_CYCLE      = 3'd1,
  parameter logic [31:0] IDCODE_VAL      = 32'h10000B6F,
  parameter int unsigned CHAIN_DW        = DTM_ABITS + 34
) (
  input  logic                       tclk,
  input  logic                       trst_b,
  input  logic                       ctrl_idr_capture_dr,
  input  logic                       ctrl_idr_update_dr,
  input  logic                       ctrl_idr_update_ir,
  input  logic [CHAIN_DW-1:0]        chain_idr_data,
  output logic [CHAIN_DW-1:0]        idr_chain_dr,
  output logic [DTM_IRREG_WIDTH-1:0] idr_chain_ir,
  output logic                       idr_dmi_mode,
  output logic                       dmihardreset,
  output logic                       dtm_apbm_wr_vld,
  output logic [DTM_ABITS-1:0]       dtm_apbm_wr_addr,
  output logic [1:0]                 dtm_apbm_wr_flg,
  output logic [31:0]                dtm_apbm_wdata,
  input  logic                       apbm_dtm_wr_ready,
  input  logic [31:0]                apbm_dtm_rdata,
  input  logic                       apbm_dtm_err
);

  localparam int unsigned PtrW = $clog2(REQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [DTM_IRREG_WIDTH-1:0] IrIdcode = DTM_IRREG_WIDTH'(5'h01);
  localparam logic [DTM_IRREG_WIDTH-1:0] IrDmiAcc = DTM_IRREG_WIDTH'(5'h02);
  localparam logic [DTM_IRREG_WIDTH-1:0] IrDtmcs  = DTM_IRREG_WIDTH'(5'h10);
  localparam logic [DTM_IRREG_WIDTH-1:0] IrDmi    = DTM_IRREG_WIDTH'(5'h11);

  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] StOk    = 2'b00;
  localparam logic [1:0] StErr   = 2'b10;
  localparam logic [1:0] StBusy  = 2'b11;

  // TAP-side registers
  logic [DTM_IRREG_WIDTH-1:0] r_ir;
  logic                       r_mode;
  logic [1:0]                 r_op_stat;
  logic                       r_hardreset;
  logic                       r_dmireset;
  logic [CHAIN_DW-1:0]        r_chain_dr;
  logic [DTM_ABITS-1:0]       r_res_addr;
  logic [31:0]                r_res_data;

  // Request queue
  logic [DTM_ABITS-1:0]       r_q_addr [REQ_DEPTH];
  logic [31:0]                r_q_data [REQ_DEPTH];
  logic [1:0]                 r_q_flg  [REQ_DEPTH];
  logic [PtrW-1:0]            r_wptr;
  logic [PtrW-1:0]            r_rptr;
  logic [CntW-1:0]            r_cnt;

  logic                       w_sel_dmi;
  logic                       w_sel_dtmcs;
  logic                       w_sel_dmiacc;
  logic                       w_empty;
  logic                       w_full;
  logic [1:0]                 w_op;
  logic                       w_req_ok;
  logic                       w_push;
  logic                       w_ovf;
  logic                       w_pop;
  logic [DTM_ABITS-1:0]       w_head_addr;
  logic [31:0]                w_head_data;
  logic [1:0]                 w_head_flg;
  logic [1:0]                 w_dmi_stat;
  logic [1:0]                 w_op_stat_d;
  logic [CHAIN_DW-1:0]        w_capture;

  assign w_sel_dmi    = (r_ir == IrDmi);
  assign w_sel_dtmcs  = (r_ir == IrDtmcs);
  assign w_sel_dmiacc = (r_ir == IrDmiAcc);

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CntW'(REQ_DEPTH));

  assign w_op     = chain_idr_data[1:0];
  assign w_req_ok = ctrl_idr_update_dr && w_sel_dmi && (w_op == OpRead || w_op == OpWrite) &&
                    !r_mode && (r_op_stat == StOk);
  // Fullness is judged on the registered count; a same-cycle pop does not make room.
  assign w_push   = w_req_ok && !w_full;
  assign w_ovf    = w_req_ok && w_full;
  assign w_pop    = !w_empty && apbm_dtm_wr_ready;

  assign w_head_addr = r_q_addr[r_rptr];
  assign w_head_data = r_q_data[r_rptr];
  assign w_head_flg  = r_q_flg[r_rptr];

  assign w_dmi_stat = (w_full || r_op_stat == StBusy) ? StBusy : r_op_stat;

  always_comb begin
    w_op_stat_d = r_op_stat;
    if (r_dmireset) begin
      w_op_stat_d = StOk;
    end
    if (w_pop && apbm_dtm_err && w_op_stat_d == StOk) begin
      w_op_stat_d = StErr;
    end
    // Overflow outranks both a pending dmireset and a bus error.
    if (w_ovf) begin
      w_op_stat_d = StBusy;
    end
  end

  always_comb begin
    w_capture = '0;
    case (r_ir)
      IrIdcode: begin
        w_capture[31:0] = IDCODE_VAL;
      end
      IrDtmcs: begin
        w_capture[18]    = w_empty;
        w_capture[14:12] = IDLE_CYCLE;
        w_capture[11:10] = r_op_stat;
        w_capture[9:4]   = 6'(DTM_ABITS);
        w_capture[3:0]   = 4'h1;
      end
      IrDmiAcc: begin
        w_capture[0] = r_mode;
      end
      IrDmi: begin
        w_capture[1:0]             = w_dmi_stat;
        w_capture[33:2]            = r_res_data;
        w_capture[34 +: DTM_ABITS] = r_res_addr;
      end
      default: begin
        w_capture = '0;
      end
    endcase
  end

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_ir        <= IrIdcode;
      r_mode      <= 1'b0;
      r_op_stat   <= StOk;
      r_hardreset <= 1'b0;
      r_dmireset  <= 1'b0;
      r_chain_dr  <= '0;
    end else begin
      r_hardreset <= ctrl_idr_update_dr && w_sel_dtmcs && chain_idr_data[17];
      r_dmireset  <= ctrl_idr_update_dr && w_sel_dtmcs && chain_idr_data[16];
      if (ctrl_idr_capture_dr) begin
        r_chain_dr <= w_capture;
      end
      if (r_hardreset) begin
        r_ir      <= IrIdcode;
        r_mode    <= 1'b0;
        r_op_stat <= StOk;
      end else begin
        if (ctrl_idr_update_ir) begin
          r_ir <= chain_idr_data[DTM_IRREG_WIDTH-1:0];
        end
        if (ctrl_idr_update_dr && w_sel_dmiacc) begin
          r_mode <= chain_idr_data[0];
        end
        r_op_stat <= w_op_stat_d;
      end
    end
  end

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else if (r_hardreset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + PtrW'(1);
        r_res_addr <= w_head_addr;
        r_res_data <= (w_head_flg == OpRead) ? apbm_dtm_rdata : w_head_data;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage needs no reset: head outputs are gated by valid.
  always_ff @(posedge tclk) begin
    if (w_push) begin
      r_q_addr[r_wptr] <= chain_idr_data[34 +: DTM_ABITS];
      r_q_data[r_wptr] <= chain_idr_data[33:2];
      r_q_flg[r_wptr]  <= w_op;
    end
  end

  assign idr_chain_dr     = r_chain_dr;
  assign idr_chain_ir     = r_ir;
  assign idr_dmi_mode     = r_mode;
  assign dmihardreset     = r_hardreset;
  assign dtm_apbm_wr_vld  = !w_empty;
  assign dtm_apbm_wr_addr = w_empty ? '0 : w_head_addr;
  assign dtm_apbm_wr_flg  = w_empty ? '0 : w_head_flg;
  assign dtm_apbm_wdata   = w_empty ? '0 : w_head_data;

endmodule

// File: tb/tb_tdt_dtm_idr_q.sv
// Directed self-checking bench for tdt_dtm_idr_q with default parameters.
module tb_tdt_dtm_idr_q;

  localparam int CDW = 50;

  logic           tclk;
  logic           trst_b;
  logic           capture_dr;
  logic           update_dr;
  logic           update_ir;
  logic [CDW-1:0] chain;
  logic [CDW-1:0] chain_dr;
  logic [4:0]     chain_ir;
  logic           dmi_mode;
  logic           hardreset;
  logic           vld;
  logic [15:0]    wr_addr;
  logic [1:0]     wr_flg;
  logic [31:0]    wdata;
  logic           ready;
  logic [31:0]    rdata;
  logic           err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CDW-1:0] cap;

  tdt_dtm_idr_q dut (
    .tclk                (tclk),
    .trst_b              (trst_b),
    .ctrl_idr_capture_dr (capture_dr),
    .ctrl_idr_update_dr  (update_dr),
    .ctrl_idr_update_ir  (update_ir),
    .chain_idr_data      (chain),
    .idr_chain_dr        (chain_dr),
    .idr_chain_ir        (chain_ir),
    .idr_dmi_mode        (dmi_mode),
    .dmihardreset        (hardreset),
    .dtm_apbm_wr_vld     (vld),
    .dtm_apbm_wr_addr    (wr_addr),
    .dtm_apbm_wr_flg     (wr_flg),
    .dtm_apbm_wdata      (wdata),
    .apbm_dtm_wr_ready   (ready),
    .apbm_dtm_rdata      (rdata),
    .apbm_dtm_err        (err)
  );

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  function automatic logic [CDW-1:0] dmi_word(input logic [15:0] a, input logic [31:0] d,
                                              input logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic upd_ir(input logic [4:0] ir);
    chain = CDW'(ir);
    update_ir = 1'b1;
    tick();
    update_ir = 1'b0;
    chain = '0;
  endtask

  task automatic upd_dr(input logic [CDW-1:0] d);
    chain = d;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    chain = '0;
  endtask

  task automatic cap_dr(output logic [CDW-1:0] v);
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    v = chain_dr;
  endtask

  task automatic dmireset();
    upd_ir(5'h10);
    upd_dr(CDW'(1) << 16);
    upd_ir(5'h11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trst_b = 1'b0; capture_dr = 1'b0; update_dr = 1'b0; update_ir = 1'b0;
    chain = '0; ready = 1'b0; rdata = '0; err = 1'b0;
    #23 trst_b = 1'b1;
    tick();

    check_eq("rst_ir", 64'(chain_ir), 64'h01);
    check_eq("rst_dr", 64'(chain_dr), 64'h0);
    check_eq("rst_out", 64'({vld, hardreset, dmi_mode, wr_addr, wr_flg, wdata}), 64'h0);

    cap_dr(cap);
    check_eq("idcode", 64'(cap[31:0]), 64'h10000B6F);
    upd_ir(5'h10);
    check_eq("ir_dtmcs", 64'(chain_ir), 64'h10);
    cap_dr(cap);
    check_eq("dtmcs_rst", 64'(cap), 64'h41101);

    // Fill the queue with ready low
    upd_ir(5'h11);
    upd_dr(dmi_word(16'h10, 32'hA0, 2'b10));
    check_eq("vld_lat", 64'(vld), 64'h1);
    for (int i = 1; i < 4; i++) upd_dr(dmi_word(16'h10 + 16'(i), 32'hA0 + 32'(i), 2'b10));
    check_eq("head_hold", 64'({wr_addr, wdata, wr_flg}), 64'({16'h10, 32'hA0, 2'b10}));
    upd_dr(dmi_word(16'h14, 32'hA4, 2'b10));
    cap_dr(cap);
    check_eq("dmi_full", 64'(cap), 64'h3);
    upd_ir(5'h10);
    cap_dr(cap);
    check_eq("dtmcs_ovf", 64'(cap), 64'h1D01);

    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("pop_order", 64'({vld, wr_addr, wdata}), 64'({1'b1, 16'h10 + 16'(i), 32'hA0 + 32'(i)}));
      tick();
    end
    ready = 1'b0;
    check_eq("drained", 64'(vld), 64'h0);
    upd_ir(5'h11);
    cap_dr(cap);
    check_eq("res_busy", 64'(cap), 64'(dmi_word(16'h13, 32'hA3, 2'b11)));
    dmireset();
    cap_dr(cap);
    check_eq("res_clr", 64'(cap), 64'(dmi_word(16'h13, 32'hA3, 2'b00)));

    // Read with bus error
    upd_dr(dmi_word(16'h04, 32'h0, 2'b01));
    check_eq("rd_head", 64'({vld, wr_addr, wr_flg}), 64'({1'b1, 16'h04, 2'b01}));
    ready = 1'b1; rdata = 32'hDEADBEEF; err = 1'b1;
    tick();
    ready = 1'b0; rdata = '0; err = 1'b0;
    cap_dr(cap);
    check_eq("rd_err", 64'(cap), 64'(dmi_word(16'h04, 32'hDEADBEEF, 2'b10)));
    upd_dr(dmi_word(16'h20, 32'h55, 2'b10));
    check_eq("err_block", 64'(vld), 64'h0);
    dmireset();
    cap_dr(cap);
    check_eq("err_clr", 64'(cap[1:0]), 64'h0);

    // Simultaneous push/pop at count 2, across pointer wrap
    upd_dr(dmi_word(16'h30, 32'hB0, 2'b10));
    upd_dr(dmi_word(16'h31, 32'hB1, 2'b10));
    ready = 1'b1;
    for (int k = 2; k < 10; k++) begin
      check_eq("pp_head", 64'({vld, wr_addr, wdata}), 64'({1'b1, 16'h30 + 16'(k - 2), 32'hB0 + 32'(k - 2)}));
      upd_dr(dmi_word(16'h30 + 16'(k), 32'hB0 + 32'(k), 2'b10));
    end
    check_eq("pp_tail0", 64'({vld, wr_addr}), 64'({1'b1, 16'h38}));
    tick();
    check_eq("pp_tail1", 64'({vld, wr_addr}), 64'({1'b1, 16'h39}));
    tick();
    check_eq("pp_empty", 64'(vld), 64'h0);
    ready = 1'b0;

    // Hard reset with requests queued
    upd_dr(dmi_word(16'h40, 32'hC0, 2'b10));
    upd_dr(dmi_word(16'h41, 32'hC1, 2'b10));
    upd_ir(5'h02);
    upd_dr(CDW'(1));
    check_eq("mode_set", 64'(dmi_mode), 64'h1);
    upd_ir(5'h10);
    upd_dr(CDW'(1) << 17);
    check_eq("hr_pulse", 64'({hardreset, vld}), 64'h3);
    tick();
    check_eq("hr_after", 64'({hardreset, vld, dmi_mode, chain_ir}), 64'h01);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_eq("hr_ready", 64'(vld), 64'h0);
    upd_ir(5'h11);
    cap_dr(cap);
    check_eq("hr_res", 64'(cap), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdt_dtm_idr_q.md
Name: tdt_dtm_idr_q

Overview:
- Next-generation DTM instruction/data register block with a parametrised ABITS and a REQ_DEPTH-entry DMI request queue.
- The debugger can pipeline several DMI writes and reads without waiting for each bus completion.
- Sits between the JTAG TAP controller (chain/capture/update strobes) and the APB master that drives the DM.
- Adds over the previous generation:
  - a sticky bus-error status;
  - a valid/ready request handshake held stable until accepted;
  - a queue-empty indication in DTMCS.

Parameters:
DTM_IRREG_WIDTH, 5, IR width; IR codes IDCODE=5'h01, DMI_ACC=5'h02, DTMCS=5'h10, DMI=5'h11
DTM_ABITS, 16, DMI address width; legal range 7..32
REQ_DEPTH, 4, request queue entries; power of two, at least 2
IDLE_CYCLE, 3'd1, value reported in DTMCS.idle
IDCODE_VAL, 32'h10000B6F, IDCODE register value
CHAIN_DW, DTM_ABITS+34, derived; shift chain width

Ports:
tclk  in  1  TCK clock; all state on rising edge
trst_b  in  1  asynchronous active-low reset
ctrl_idr_capture_dr  in  1  Capture-DR pulse
ctrl_idr_update_dr  in  1  Update-DR pulse
ctrl_idr_update_ir  in  1  Update-IR pulse
chain_idr_data  in  CHAIN_DW  shifted-in data (IR uses low DTM_IRREG_WIDTH bits)
idr_chain_dr  out  CHAIN_DW  parallel load for the selected DR
idr_chain_ir  out  DTM_IRREG_WIDTH  current IR
idr_dmi_mode  out  1  DMI_ACC mode bit
dmihardreset  out  1  one-cycle hard-reset pulse
dtm_apbm_wr_vld  out  1  queue head valid
dtm_apbm_wr_addr  out  DTM_ABITS  head address
dtm_apbm_wr_flg  out  2  head op (01 read, 10 write)
dtm_apbm_wdata  out  32  head write data
apbm_dtm_wr_ready  in  1  head accepted and completed this cycle
apbm_dtm_rdata  in  32  read data, valid with ready
apbm_dtm_err  in  1  bus error, valid with ready

Behaviour:
- Reset: all outputs 0 except idr_chain_ir=IDCODE; IR=IDCODE, queue empty, op_stat=0, result register 0, mode=0.
- IR: loads on update_ir. dmihardreset forces IDCODE.
- DTMCS capture: {zeros, qempty[18], idle[14:12], op_stat[11:10], abits[9:4], version=4'h1[3:0]}.
- DTMCS update:
  - bit17=1: dmihardreset pulses high for one cycle.
  - bit16=1: dmireset pulses for one cycle; it clears op_stat.
- DMI_ACC: update loads mode from bit0. Capture returns {0, mode}. While mode=1, DMI updates are not queued.
- DMI capture: {res_addr, res_data, stat}, where res_* is the most recently completed request.
  - stat = 2'b11 if the queue is full or op_stat=3.
  - Otherwise stat = op_stat.
  - Capture never modifies state.
- DMI update, with op=chain_idr_data[1:0], address=[34+:ABITS], data=[33:2]:
  - op 00 or 11, or mode=1, or op_stat!=0: ignored.
  - Queue full, judged on registered count: dropped; op_stat <= 2'b11.
  - Otherwise: entry pushed at the next edge; count increments.
- Handshake:
  - dtm_apbm_wr_vld = queue non-empty. addr/flg/wdata come from the head and are held stable while vld=1.
  - Pop on a cycle where vld and ready are both high.
  - ready with vld=0 is ignored.
  - Latency: update at cycle N gives vld=1 at N+1 when the queue was empty.
- Completion, on pop:
  - res_addr <= head address.
  - res_data <= rdata for a read, head wdata for a write.
  - If err=1 and op_stat==0: op_stat <= 2'b10.
  - Higher-priority 2'b11 is never overwritten by 2'b10.
- Push and pop in the same cycle: count unchanged; ordering preserved.
- Pointers wrap modulo REQ_DEPTH. Count width is clog2(REQ_DEPTH)+1.
- dmihardreset (cycle after the DTMCS update):
  - Clears queue, op_stat, result, mode and IR.
  - vld drops the following cycle. Any in-flight ready is ignored once the queue is empty.
- dmireset and a same-cycle overflow: overflow wins; op_stat=3.

Test Plan:
- Reset, then IR=IDCODE Capture-DR -> idr_chain_dr low 32 bits = 32'h10000B6F; DTMCS capture -> 0x40000 | 0x1000 | (16<<4) | 1.
- Four back-to-back DMI writes (addr 0x10..0x13, data 0xA0..0xA3) with ready held low -> vld=1 one cycle after the first update; head stays 0x10/0xA0. A fifth write -> dropped, DMI capture stat=2'b11, DTMCS op_stat=3.
- Then ready pulses four times -> pops in order 0x10..0x13. Queue empty; DMI capture = {0x13, 0xA3, 2'b11} until a DTMCS dmireset, then stat=00.
- DMI read addr 0x04; ready with rdata=0xDEADBEEF, err=1 -> capture {0x04, 0xDEADBEEF, 2'b10}. The next DMI update is ignored (no vld) until dmireset.
- Push and pop in the same cycle with count=2 -> count stays 2; FIFO order intact across pointer wrap (8+ requests).
- Two writes queued, then a DTMCS write with bit17=1 -> dmihardreset pulses for one cycle; vld=0 next cycle; IR=IDCODE; a subsequent ready causes no state change.
